// File: rtl/twiddle_fetch_pkg.sv
// Shared constants for the twiddle fetch unit: FSM state encodings.
package twiddle_fetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/tw_skid_fifo.sv
// Two-entry FIFO holding captured twiddles. An empty FIFO presents zero data so
// nothing stale is visible on the output after a run or a reset.
module tw_skid_fifo #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/twiddle_fetch.sv
// Walks the radix-2 DIT twiddle order, reads each W^k from the ROM and streams it,
// tagged with its stage and a last flag, to the butterfly unit.
module twiddle_fetch
  import twiddle_fetch_pkg::*;
#(
  parameter int WORDSIZE = 16,
  parameter int ADDRSIZE = 8,
  parameter int LOG2N    = 8,
  localparam int SW      = $clog2(LOG2N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rom_cs,
  output logic [ADDRSIZE-1:0] rom_addr,
  input  logic [WORDSIZE-1:0] rom_data1,
  input  logic [WORDSIZE-1:0] rom_data2,
  output logic                tw_valid,
  input  logic                tw_ready,
  output logic [WORDSIZE-1:0] tw_re,
  output logic [WORDSIZE-1:0] tw_im,
  output logic [SW-1:0]       tw_stage,
  output logic                tw_last,
  output logic [1:0]          fsm_state
);

  localparam int JW = LOG2N - 1;
  localparam int HALF = 2 ** JW;
  localparam int FW = 2 * WORDSIZE + SW + 1;
  localparam logic [SW-1:0] JW_S = SW'(JW);

  logic [1:0]    state;
  logic [SW-1:0] s_cnt;
  logic [JW-1:0] j_cnt;
  logic [JW-1:0] j_mask;
  logic [JW-1:0] k_idx;
  logic          last_issue;
  logic          issue;
  logic          pop;
  logic [2:0]    occ;
  logic          in_flight;
  logic [SW-1:0] fl_stage;
  logic          fl_last;
  logic [FW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic [1:0]    count;

  // k = (j mod 2^s) << (LOG2N-1-s); at the top stage the mask wraps to all ones.
  always_comb begin
    j_mask = (JW'(1) << s_cnt) - JW'(1);
    k_idx  = (j_cnt & j_mask) << (JW_S - s_cnt);
  end

  // Stream handshake: a word moves when tw_valid && tw_ready on a rising edge;
  // head data is held unchanged while tw_valid && !tw_ready.
  assign pop        = tw_valid && tw_ready;
  assign last_issue = (s_cnt == SW'(LOG2N - 1)) && (j_cnt == JW'(HALF - 1));
  // Occupancy the FIFO will have after this edge, counting the word in flight.
  assign occ        = 3'(count) + {2'b00, in_flight} - {2'b00, pop};
  assign issue      = (state == ST_RUN) && (occ < 3'd2) && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s_cnt     <= '0;
      j_cnt     <= '0;
      in_flight <= 1'b0;
      fl_stage  <= '0;
      fl_last   <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        fl_stage <= s_cnt;
        fl_last  <= last_issue;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            s_cnt <= '0;
            j_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (last_issue) begin
              state <= ST_DRAIN;
              s_cnt <= '0;
              j_cnt <= '0;
            end else if (j_cnt == JW'(HALF - 1)) begin
              s_cnt <= s_cnt + SW'(1);
              j_cnt <= '0;
            end else begin
              j_cnt <= j_cnt + JW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (occ == 3'd0) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tw_skid_fifo #(.W(FW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_flight),
    .pop     (pop),
    .wr_data ({rom_data1, rom_data2, fl_stage, fl_last}),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign tw_valid  = !empty;
  assign tw_re     = rd_data[FW-1 -: WORDSIZE];
  assign tw_im     = rd_data[SW + WORDSIZE : SW + 1];
  assign tw_stage  = rd_data[SW:1];
  assign tw_last   = rd_data[0];

  assign rom_cs    = (state == ST_RUN) || (state == ST_DRAIN);
  assign rom_addr  = (state == ST_RUN) ? ADDRSIZE'(k_idx) : '0;
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_twiddle_fetch.sv
// Bench for twiddle_fetch: ROM model re=k, im=0x100+k; randomized ready against a
// reference list of twiddles built from the DIT ordering rule.
module tb_twiddle_fetch;
  import twiddle_fetch_pkg::*;

  localparam int WS    = 16;
  localparam int AS    = 8;
  localparam int L2N   = 8;
  localparam int SW    = 3;
  localparam int HALF  = 128;
  localparam int TOTAL = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          tw_ready = 1'b0;
  logic          busy, done, rom_cs, tw_valid, tw_last;
  logic [AS-1:0] rom_addr;
  logic [WS-1:0] rom_data1, rom_data2, tw_re, tw_im;
  logic [WS-1:0] rom_re_q, rom_im_q;
  logic [SW-1:0] tw_stage;
  logic [1:0]    fsm_state;

  int n_checks = 0;
  int n_pass = 0;
  logic [35:0] exp_q[$];
  logic [35:0] got_words [TOTAL];

  always #5 clk = ~clk;

  // Registered ROM; an undriven bus is modelled as a poison value.
  always @(posedge clk) begin
    if (rom_cs) begin
      rom_re_q <= 16'(rom_addr);
      rom_im_q <= 16'h100 + 16'(rom_addr);
    end
  end
  assign rom_data1 = rom_cs ? rom_re_q : 16'hDEAD;
  assign rom_data2 = rom_cs ? rom_im_q : 16'hDEAD;

  twiddle_fetch #(.WORDSIZE(WS), .ADDRSIZE(AS), .LOG2N(L2N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_data1 (rom_data1),
    .rom_data2 (rom_data2),
    .tw_valid  (tw_valid),
    .tw_ready  (tw_ready),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .tw_stage  (tw_stage),
    .tw_last   (tw_last),
    .fsm_state (fsm_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [35:0] head_word();
    return {tw_re, tw_im, tw_stage, tw_last};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check(tag, {busy, done, rom_cs, rom_addr, tw_valid, tw_re, tw_im, tw_stage, tw_last}, 64'd0);
    check({tag, "_state"}, fsm_state, ST_IDLE);
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int s = 0; s < L2N; s++) begin
      for (int j = 0; j < HALF; j++) begin
        int  k;
        logic lst;
        k   = (j % (1 << s)) * (1 << (L2N - 1 - s));
        lst = (s == L2N - 1) && (j == HALF - 1);
        exp_q.push_back({16'(k), 16'(256 + k), 3'(s), lst});
      end
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low 20 cycles then random.
  task automatic run_seq(input int mode, input int abort_at, input bit extra_starts);
    int   cnt, idx, first_valid, last_hs, done_pulses;
    bit   stalled, hold_ok;
    logic [36:0] held;
    logic [35:0] e;
    build_exp();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0; idx = 0; first_valid = -1; last_hs = -1;
    stalled = 1'b0; hold_ok = 1'b1; held = '0;
    check("busy_after_start", busy, 1);
    while (idx < TOTAL && cnt < 6000) begin
      if (abort_at > 0 && idx >= abort_at) begin
        check("abort_in_stage3", tw_stage, 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; tw_ready = 1'b0;
        return;
      end
      if (stalled) check("stall_stable", {tw_valid, head_word()}, held);
      if (tw_valid && first_valid < 0) first_valid = cnt;
      case (mode)
        0:       tw_ready = 1'b1;
        1:       tw_ready = 1'($urandom_range(0, 1));
        default: tw_ready = (cnt < 20) ? 1'b0 : 1'($urandom_range(0, 1));
      endcase
      if (mode == 2 && cnt < 20 && cnt >= 2 && head_word() !== {16'h0, 16'h100, 3'd0, 1'b0})
        hold_ok = 1'b0;
      start   = extra_starts && ($urandom_range(0, 39) == 0);
      stalled = tw_valid && !tw_ready;
      held    = {tw_valid, head_word()};
      if (tw_valid && tw_ready) begin
        e = exp_q.pop_front();
        check("word", head_word(), e);
        got_words[idx] = head_word();
        idx++;
        last_hs = cnt;
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check("word_count", idx, TOTAL);
    check("first_valid_latency", first_valid, 2);
    if (mode == 0) check("back_to_back", last_hs, 2 + TOTAL - 1);
    if (mode == 2) check("hold_first_word", hold_ok, 1);
    check("done_after_last", done, 1);
    done_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_pulses++;
      @(negedge clk);
    end
    check("done_once", done_pulses, 1);
    check("busy_low_after", busy, 0);
    check("idle_after", fsm_state, ST_IDLE);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    run_seq(0, 0, 1'b0);
    check("s0_j0_word", got_words[0], {16'h0, 16'h100, 3'd0, 1'b0});
    check("s7_j5_re", got_words[7 * HALF + 5][35:20], 5);
    check("s1_j3_re", got_words[HALF + 3][35:20], 64);
    check("s1_j3_im", got_words[HALF + 3][19:4], 16'h140);
    check("last_tag", got_words[TOTAL - 1][0], 1);
    check("not_last_tag", got_words[TOTAL - 2][0], 0);

    run_seq(1, 0, 1'b0);
    run_seq(2, 0, 1'b0);
    run_seq(1, 3 * HALF + 10, 1'b0);
    run_seq(0, 0, 1'b0);
    run_seq(1, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
